mii_rx_frame_capture: RTL



---
 rtl/mii_rx_frame_capture_if.sv | 30 +++
 rtl/mii_rx_frame_capture.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mii_rx_frame_capture_if.sv
// Capture-engine bus: MII receive inputs, held-frame status, buffer read port and frame release.
interface mii_rx_frame_capture_if #(
  parameter int DEPTH_BYTES = 2048,
  parameter int WORD_BYTES  = 4,
  parameter int LEN_W       = $clog2(DEPTH_BYTES + 1),
  parameter int ADDR_W      = $clog2(DEPTH_BYTES / WORD_BYTES)
);
  logic                    i_en;
  logic                    i_rx_dv;
  logic [3:0]              i_rx_data;
  logic [ADDR_W-1:0]       i_rd_addr;
  logic [8*WORD_BYTES-1:0] o_rd_data;
  logic                    o_frame_valid;
  logic [LEN_W-1:0]        o_frame_len;
  logic                    o_frame_ok;
  logic                    o_overflow;
  logic                    o_crc_ok;
  logic                    i_frame_ack;
  logic [15:0]             o_drop_cnt;

  modport master (
    input  i_en, i_rx_dv, i_rx_data, i_rd_addr, i_frame_ack,
    output o_rd_data, o_frame_valid, o_frame_len, o_frame_ok, o_overflow, o_crc_ok, o_drop_cnt
  );

  modport slave (
    output i_en, i_rx_dv, i_rx_data, i_rd_addr, i_frame_ack,
    input  o_rd_data, o_frame_valid, o_frame_len, o_frame_ok, o_overflow, o_crc_ok, o_drop_cnt
  );
endinterface

// File: rtl/mii_rx_frame_capture.sv
// MII receive capture: strips preamble/SFD, packs bytes MSB-lane-first into a word buffer, holds one frame.
// Optional FCS checking is built when MII_RX_CRC_EN is defined.
module mii_rx_frame_capture #(
  parameter int DEPTH_BYTES = 2048,
  parameter int WORD_BYTES  = 4,
  parameter int LEN_W       = $clog2(DEPTH_BYTES + 1),
  parameter int ADDR_W      = $clog2(DEPTH_BYTES / WORD_BYTES)
) (
  input  logic                  i_clk,
  input  logic                  i_nreset,
  mii_rx_frame_capture_if.master bus
);
  localparam int WORDS = DEPTH_BYTES / WORD_BYTES;
  localparam int DW    = 8 * WORD_BYTES;
  localparam logic [LEN_W-1:0] DEPTH_L   = LEN_W'(DEPTH_BYTES);
  localparam logic [LEN_W-1:0] LAST_LANE = LEN_W'(WORD_BYTES - 1);

  typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_DATA, S_HOLD, S_DROP} state_t;
  state_t state, state_nx;

  logic [LEN_W-1:0] byte_cnt;
  logic [3:0]       low_nib;
  logic             half;
  logic             ovf;
  logic [DW-1:0]    word_acc;
  logic             dv_q;
  logic [DW-1:0]    mem [WORDS];
  logic [DW-1:0]    rd_data;

  logic             frame_valid, frame_ok, overflow;
  logic [LEN_W-1:0] frame_len;
  logic [15:0]      drop_cnt;

  logic start_frame, take_nib, end_frame, drop_inc, release_frame;
  logic crc_good;

  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) state <= S_IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    start_frame   = 1'b0;
    take_nib      = 1'b0;
    end_frame     = 1'b0;
    drop_inc      = 1'b0;
    release_frame = 1'b0;
    unique case (state)
      S_IDLE:
        if (bus.i_en && bus.i_rx_dv) begin
          if (bus.i_rx_data == 4'h5) state_nx = S_PREAMBLE;
          else begin
            state_nx = S_DROP;
            drop_inc = 1'b1;
          end
        end
      S_PREAMBLE:
        if (!bus.i_rx_dv) state_nx = S_IDLE;
        else if (bus.i_rx_data == 4'hD) begin
          state_nx    = S_DATA;
          start_frame = 1'b1;
        end else if (bus.i_rx_data != 4'h5) begin
          state_nx = S_DROP;
          drop_inc = 1'b1;
        end
      S_DATA:
        if (bus.i_rx_dv) take_nib = 1'b1;
        else begin
          end_frame = 1'b1;
          state_nx  = S_HOLD;
        end
      S_HOLD: begin
        // A frame already counted at its dv rising edge is not counted again when ack sends it to DROP
        drop_inc = bus.i_rx_dv && !dv_q;
        if (bus.i_frame_ack) begin
          release_frame = 1'b1;
          state_nx      = bus.i_rx_dv ? S_DROP : S_IDLE;
        end
      end
      S_DROP:
        if (!bus.i_rx_dv) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  logic [7:0]       new_byte;
  logic             byte_done, room;
  logic [LEN_W-1:0] lane;
  logic [DW-1:0]    word_nx;
  logic             mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DW-1:0]    mem_wd;

  assign new_byte  = {bus.i_rx_data, low_nib};
  assign byte_done = take_nib && half;
  assign room      = (byte_cnt != DEPTH_L);
  assign lane      = byte_cnt % LEN_W'(WORD_BYTES);

  always_comb begin
    word_nx = word_acc;
    for (int unsigned l = 0; l < WORD_BYTES; l++)
      if (LEN_W'(l) == lane) word_nx[DW-1-8*l -: 8] = new_byte;
  end

  // Lanes beyond the last byte stay zero because word_acc is cleared after every full-word write
  assign mem_we = (byte_done && room && (lane == LAST_LANE)) || (end_frame && (lane != '0));
  assign mem_wa = ADDR_W'(byte_cnt / LEN_W'(WORD_BYTES));
  assign mem_wd = end_frame ? word_acc : word_nx;

  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      byte_cnt <= '0;
      low_nib  <= '0;
      half     <= 1'b0;
      ovf      <= 1'b0;
      word_acc <= '0;
      dv_q     <= 1'b0;
    end else begin
      dv_q <= bus.i_rx_dv;
      if (start_frame) begin
        byte_cnt <= '0;
        half     <= 1'b0;
        ovf      <= 1'b0;
        word_acc <= '0;
      end else if (take_nib) begin
        half <= !half;
        if (!half) low_nib <= bus.i_rx_data;
        else if (room) begin
          byte_cnt <= byte_cnt + LEN_W'(1);
          word_acc <= (lane == LAST_LANE) ? '0 : word_nx;
        end else ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) rd_data <= '0;
    else           rd_data <= mem[bus.i_rd_addr];
  end

  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      frame_valid <= 1'b0;
      frame_len   <= '0;
      frame_ok    <= 1'b0;
      overflow    <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      if (end_frame) begin
        frame_valid <= 1'b1;
        frame_len   <= byte_cnt;
        overflow    <= ovf;
        frame_ok    <= !ovf && !half && crc_good;
      end else if (release_frame) frame_valid <= 1'b0;
      if (drop_inc && (drop_cnt != '1)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

`ifdef MII_RX_CRC_EN
  logic [31:0] crc, crc_nx;
  logic        crc_ok_q;

  always_comb begin
    crc_nx = crc ^ {24'h0, new_byte};
    for (int unsigned b = 0; b < 8; b++)
      crc_nx = crc_nx[0] ? ((crc_nx >> 1) ^ 32'hEDB88320) : (crc_nx >> 1);
  end

  // Overflowed bytes still feed the CRC so the FCS of a long frame is still checked
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      crc      <= '1;
      crc_ok_q <= 1'b0;
    end else begin
      if (start_frame)    crc <= '1;
      else if (byte_done) crc <= crc_nx;
      if (end_frame) crc_ok_q <= crc_good;
    end
  end

  assign crc_good   = (crc == 32'hDEBB20E3);
  assign bus.o_crc_ok = crc_ok_q;
`else
  assign crc_good   = 1'b1;
  assign bus.o_crc_ok = 1'b1;
`endif

  assign bus.o_rd_data     = rd_data;
  assign bus.o_frame_valid = frame_valid;
  assign bus.o_frame_len   = frame_len;
  assign bus.o_frame_ok    = frame_ok;
  assign bus.o_overflow    = overflow;
  assign bus.o_drop_cnt    = drop_cnt;
endmodule
